// File: rtl/pmod_pkg.sv
// Shared types and width constants for the PMOD 74HC165 chain reader.
package pmod_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETTLE,
    CLK_HI,
    CLK_LO,
    DONE
  } pmod_state_t;

  // Phase counter covers the full legal CLK_DIV range of 4..255.
  localparam int DIV_W = $clog2(256);

  // Bit counter must be able to hold the value BITS itself.
  function automatic int bit_w(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/pmod_shift_reader_sync_2ff.sv
// Multi-bit two-flop synchronizer for the asynchronous serial data lines.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] async_data,
  output logic [WIDTH-1:0] sync_data
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= async_data;
      sync_reg <= meta_reg;
    end
  end

  assign sync_data = sync_reg;

endmodule

// File: rtl/pmod_shift_reader.sv
// Polls a 74HC165-style parallel-in/serial-out chain and presents each
// complete frame of NUM_CH x BITS bits with a one-cycle valid strobe.
module pmod_shift_reader
  import pmod_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int BITS        = 8,
  parameter int NUM_CH      = 3,
  parameter int POLL_PERIOD = 100000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   trigger_in,
  input  logic [NUM_CH-1:0]      ser_data_in,
  output logic                   ser_clk_out,
  output logic                   ser_latch_out,
  output logic [NUM_CH*BITS-1:0] data_out,
  output logic                   data_valid_out,
  output logic                   busy_out
);

  localparam int          BIT_W     = bit_w(BITS);
  localparam logic [31:0] POLL_LAST = 32'(POLL_PERIOD - 1);

  pmod_state_t state_reg, state_next;
  logic [DIV_W-1:0] phase_reg, phase_next;
  logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [31:0]      poll_reg, poll_next;
  logic             pending_reg, pending_next;

  logic             ser_clk_reg;
  logic             ser_latch_reg;
  logic             busy_reg;
  logic             valid_reg;
  logic [NUM_CH*BITS-1:0] data_reg;

  logic                   sample;
  logic                   phase_last;
  logic                   poll_hit;
  logic [NUM_CH-1:0]      data_sync;
  logic [NUM_CH*BITS-1:0] frame_next;

  sync_2ff #(
    .WIDTH (NUM_CH)
  ) u_sync (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .async_data (ser_data_in),
    .sync_data  (data_sync)
  );

  assign phase_last = (phase_reg == DIV_W'(CLK_DIV - 1));
  assign poll_hit   = (POLL_PERIOD != 0) && (poll_reg == POLL_LAST);

  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_last ? '0 : phase_reg + DIV_W'(1);
    bit_cnt_next = bit_cnt_reg;
    poll_next    = '0;
    pending_next = pending_reg | trigger_in;
    sample       = 1'b0;

    case (state_reg)
      IDLE: begin
        phase_next   = '0;
        pending_next = pending_reg;
        poll_next    = (POLL_PERIOD == 0 || poll_hit) ? '0 : poll_reg + 32'd1;
        if (poll_hit || trigger_in || pending_reg) begin
          state_next   = LATCH;
          pending_next = 1'b0;
          poll_next    = '0;
        end
      end
      LATCH: begin
        if (phase_last) state_next = SETTLE;
      end
      SETTLE: begin
        if (phase_last) begin
          sample       = 1'b1;
          bit_cnt_next = BIT_W'(1);
          state_next   = CLK_HI;
        end
      end
      CLK_HI: begin
        if (phase_last) state_next = CLK_LO;
      end
      CLK_LO: begin
        // Sampling at the very end of the low phase gives the chain and the
        // synchronizer the most time to settle after the rising edge.
        if (phase_last) begin
          sample       = 1'b1;
          bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          state_next   = (bit_cnt_reg == BIT_W'(BITS - 1)) ? DONE : CLK_HI;
        end
      end
      DONE: begin
        phase_next   = '0;
        bit_cnt_next = '0;
        // A queued request chains straight into the next frame.
        if (pending_reg || trigger_in) begin
          state_next   = LATCH;
          pending_next = 1'b0;
        end else begin
          state_next   = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        pending_next = 1'b0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [BITS-1:0] shift_reg;
      logic [BITS-1:0] shift_next;

      assign shift_next = sample ? {shift_reg[BITS-2:0], data_sync[gi]} : shift_reg;
      assign frame_next[gi*BITS +: BITS] = shift_next;

      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) shift_reg <= '0;
        else        shift_reg <= shift_next;
      end
    end
  endgenerate

  // Outputs are decoded from the next state so they line up with the state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg     <= IDLE;
      phase_reg     <= '0;
      bit_cnt_reg   <= '0;
      poll_reg      <= '0;
      pending_reg   <= 1'b0;
      ser_clk_reg   <= 1'b0;
      ser_latch_reg <= 1'b0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      data_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      bit_cnt_reg   <= bit_cnt_next;
      poll_reg      <= poll_next;
      pending_reg   <= pending_next;
      ser_clk_reg   <= (state_next == CLK_HI);
      ser_latch_reg <= (state_next == LATCH);
      busy_reg      <= (state_next != IDLE);
      valid_reg     <= (state_next == DONE);
      if (state_next == DONE) data_reg <= frame_next;
    end
  end

  assign ser_clk_out    = ser_clk_reg;
  assign ser_latch_out  = ser_latch_reg;
  assign busy_out       = busy_reg;
  assign data_valid_out = valid_reg;
  assign data_out       = data_reg;

endmodule

// File: tb/tb_pmod_shift_reader.sv
// Directed bench for pmod_shift_reader driving a behavioural 74HC165 chain per channel.
module tb_pmod_shift_reader;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        trigger_in = 1'b0;
  logic [2:0]  ser_data_in;
  logic        ser_clk_out;
  logic        ser_latch_out;
  logic [23:0] data_out;
  logic        data_valid_out;
  logic        busy_out;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk_in = ~clk_in;

  pmod_shift_reader #(
    .CLK_DIV     (4),
    .BITS        (8),
    .NUM_CH      (3),
    .POLL_PERIOD (200)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .trigger_in     (trigger_in),
    .ser_data_in    (ser_data_in),
    .ser_clk_out    (ser_clk_out),
    .ser_latch_out  (ser_latch_out),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .busy_out       (busy_out)
  );

  // 74HC165 model: load while latch high, shift on rising shift clock,
  // output visible model_delay cycles after the DUT clock edge.
  logic [7:0] load_val [3];
  logic [7:0] mreg [3];
  logic [7:0] pipe [3];
  logic       prev_sclk_m = 1'b0;
  int         model_delay = 3;

  always @(posedge clk_in) begin
    prev_sclk_m <= ser_clk_out;
    for (int c = 0; c < 3; c++) begin
      if (ser_latch_out)                    mreg[c] <= load_val[c];
      else if (ser_clk_out && !prev_sclk_m) mreg[c] <= {mreg[c][6:0], 1'b0};
      pipe[c] <= {pipe[c][6:0], mreg[c][7]};
    end
  end

  always_comb begin
    ser_data_in = '0;
    for (int c = 0; c < 3; c++)
      ser_data_in[c] = (model_delay <= 1) ? mreg[c][7] : pipe[c][model_delay-2];
  end

  // Event monitor: cycle indices of latch entry and valid, edge counts.
  int   cyc = 0, latch_cyc = 0, valid_cyc = 0, frames = 0, valids = 0, clk_edges = 0;
  logic prev_latch = 1'b0, prev_sclk = 1'b0;

  always @(posedge clk_in) begin
    cyc        <= cyc + 1;
    prev_latch <= ser_latch_out;
    prev_sclk  <= ser_clk_out;
    if (ser_latch_out && !prev_latch) begin
      latch_cyc <= cyc;
      frames    <= frames + 1;
      clk_edges <= 0;
    end else if (ser_clk_out && !prev_sclk) begin
      clk_edges <= clk_edges + 1;
    end
    if (data_valid_out) begin
      valid_cyc <= cyc;
      valids    <= valids + 1;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic set_loads(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    load_val[0] = a;
    load_val[1] = b;
    load_val[2] = c;
  endtask

  task automatic pulse_trigger();
    trigger_in = 1'b1;
    @(negedge clk_in);
    trigger_in = 1'b0;
  endtask

  task automatic wait_valids(input int target, input int budget);
    int n = 0;
    while (valids < target && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    if (valids < target) check_vec("timeout", valids, target);
  endtask

  int base, f0, d1, d2, d3, d4, l1, l2, n;

  initial begin
    set_loads(8'h00, 8'h00, 8'h00);
    #2 rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check_vec("rst_data",  data_out, 0);
    check_vec("rst_busy",  busy_out, 0);
    check_vec("rst_sclk",  ser_clk_out, 0);
    check_vec("rst_latch", ser_latch_out, 0);
    check_vec("rst_valid", data_valid_out, 0);
    rst_in = 1'b0;

    // Single triggered frame
    set_loads(8'hA5, 8'h3C, 8'hFF);
    @(negedge clk_in);
    base = valids;
    pulse_trigger();
    repeat (30) @(negedge clk_in);
    check_vec("a_busy", busy_out, 1);
    check_vec("a_hold", data_out, 0);
    wait_valids(base + 1, 100);
    repeat (3) @(negedge clk_in);
    check_vec("a_data",      data_out, 24'hFF3CA5);
    check_vec("a_valid_len", valids - base, 1);
    check_vec("a_frame_len", valid_cyc - latch_cyc, 64);
    check_vec("a_edges",     clk_edges, 7);
    check_vec("a_idle",      busy_out, 0);

    // Three triggers while busy queue exactly one chained frame
    set_loads(8'h12, 8'h34, 8'h56);
    base = valids;
    f0   = frames;
    pulse_trigger();
    repeat (10) @(negedge clk_in);
    repeat (3) begin
      pulse_trigger();
      repeat (4) @(negedge clk_in);
    end
    wait_valids(base + 1, 100);
    d1 = valid_cyc;
    repeat (3) @(negedge clk_in);
    check_vec("b_chain",   latch_cyc, d1 + 1);
    check_vec("b_started", frames - f0, 2);
    wait_valids(base + 2, 100);
    d2 = valid_cyc;
    l2 = latch_cyc;
    repeat (80) @(negedge clk_in);
    check_vec("b_extra", frames - f0, 2);
    check_vec("b_data",  data_out, 24'h563412);

    // Auto-poll only
    set_loads(8'h00, 8'h00, 8'h00);
    base = valids;
    wait_valids(base + 1, 300);
    l1 = latch_cyc;
    check_vec("c_period1", l1 - l2, 265);
    check_vec("c_data0",   data_out, 0);
    set_loads(8'h81, 8'h81, 8'h81);
    wait_valids(base + 2, 300);
    check_vec("c_period2", latch_cyc - l1, 265);
    check_vec("c_data1",   data_out, 24'h818181);

    // Trigger on the same cycle the poll counter expires
    set_loads(8'hE7, 8'h18, 8'hC3);
    d3   = valid_cyc;
    base = valids;
    f0   = frames;
    n    = 0;
    while (cyc < d3 + 200 && n < 400) begin
      @(negedge clk_in);
      n++;
    end
    pulse_trigger();
    wait_valids(base + 1, 100);
    d4 = valid_cyc;
    check_vec("d_start", latch_cyc, d3 + 201);
    check_vec("d_data",  data_out, 24'hC318E7);
    wait_valids(base + 2, 300);
    check_vec("d_frames",  frames - f0, 2);
    check_vec("d_restart", latch_cyc, d4 + 201);

    // Late data edge: model output moves 5 cycles after the shift clock
    model_delay = 5;
    set_loads(8'hC3, 8'h5A, 8'h96);
    base = valids;
    pulse_trigger();
    repeat (30) @(negedge clk_in);
    check_vec("e_hold", data_out, 24'hC318E7);
    wait_valids(base + 1, 100);
    check_vec("e_data", data_out, 24'h965AC3);

    // Reset in the middle of a high shift-clock phase
    model_delay = 3;
    set_loads(8'h11, 8'h22, 8'h33);
    @(negedge clk_in);
    pulse_trigger();
    n = 0;
    while (!ser_clk_out && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    check_vec("f_sclk_seen", ser_clk_out, 1);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    check_vec("f_sclk",  ser_clk_out, 0);
    check_vec("f_latch", ser_latch_out, 0);
    check_vec("f_data",  data_out, 0);
    check_vec("f_busy",  busy_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    set_loads(8'h0F, 8'hF0, 8'h69);
    @(negedge clk_in);
    base = valids;
    pulse_trigger();
    wait_valids(base + 1, 100);
    repeat (2) @(negedge clk_in);
    check_vec("f_clean_data", data_out, 24'h69F00F);
    check_vec("f_clean_len",  valid_cyc - latch_cyc, 64);
    check_vec("f_clean_edges", clk_edges, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
